// File: rtl/scanner_tx_serializer.sv
// Scanner byte FIFO feeding an MSB-first bit serializer towards the transfer center.
// Latency: byte written at edge t -> request after t+1, first bit after t+2 when the transfer center is ready.
// Backpressure: byte_in_ready drops when the FIFO is full (writes then dropped, overflow sticky); shifting waits in REQUEST.
module scanner_tx_serializer #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_in_valid,
    input  logic [7:0]    byte_in,
    output logic          byte_in_ready,
    input  logic          ready_for_transfer_in,
    output logic          ready_for_transfer_out,
    output logic          data_out,
    output logic          data_valid,
    output logic [2:0]    byte_counter,
    output logic [CW-1:0] fill_level,
    output logic          overflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rdy_q, dv_q, req_q, ovf_q;
    logic            push, load;

    // Write acceptance uses the registered ready only, so a same-edge pop never frees a slot early.
    assign push = byte_in_valid && rdy_q;

    // Next-state, shift register and bit counter; a load pops the FIFO head into the shifter.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = REQUEST;
            end
            REQUEST: begin
                if (ready_for_transfer_in) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[6:0], 1'b0};
                if (cnt_q == 3'd7) begin
                    cnt_d = 3'd0;
                    if (count_q != '0 && ready_for_transfer_in) begin
                        load = 1'b1;
                    end else if (count_q != '0) begin
                        state_d = REQUEST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            shift_d = mem_q[rd_ptr_q];
            cnt_d   = 3'd0;
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !load)      count_d = count_q + CW'(1);
        else if (!push && load) count_d = count_q - CW'(1);
    end

    // FIFO storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= byte_in;
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= 8'h00;
            cnt_q    <= 3'd0;
            rdy_q    <= 1'b1;
            dv_q     <= 1'b0;
            req_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            rdy_q    <= (count_d < DEPTH_C);
            dv_q     <= (state_d == SHIFT);
            req_q    <= (state_d == REQUEST);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (byte_in_valid && !rdy_q) ovf_q <= 1'b1;
        end
    end

    assign byte_in_ready          = rdy_q;
    assign ready_for_transfer_out = req_q;
    assign data_out               = shift_q[7];
    assign data_valid             = dv_q;
    assign byte_counter           = cnt_q;
    assign fill_level             = count_q;
    assign overflow               = ovf_q;

endmodule

// File: tb/tb_scanner_tx_serializer.sv
// Bench for scanner_tx_serializer: scoreboard of written bytes versus reassembled serial output.
// Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
// Table rows drive back-to-back bursts; hand sequences cover latency, stalls, overflow, reset and push/pop collision.
module tb_scanner_tx_serializer;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          byte_in_valid = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_in_ready;
    logic          ready_for_transfer_in = 1'b0;
    logic          ready_for_transfer_out;
    logic          data_out;
    logic          data_valid;
    logic [2:0]    byte_counter;
    logic [CW-1:0] fill_level;
    logic          overflow;

    scanner_tx_serializer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .byte_in_valid          (byte_in_valid),
        .byte_in                (byte_in),
        .byte_in_ready          (byte_in_ready),
        .ready_for_transfer_in  (ready_for_transfer_in),
        .ready_for_transfer_out (ready_for_transfer_out),
        .data_out               (data_out),
        .data_valid             (data_valid),
        .byte_counter           (byte_counter),
        .fill_level             (fill_level),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        int         exp_valid;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sb [$];
    logic [7:0]  acc = 8'h00;
    int          bit_idx = 0;
    int          vcnt = 0;
    int          runs = 0;
    logic        prev_dv = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: sample and reassemble on the falling edge, return 2ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            bit_idx = 0;
            acc     = 8'h00;
            prev_dv = 1'b0;
        end else begin
            if (data_valid) begin
                chk("bit_index", 32'(byte_counter), 32'(bit_idx));
                acc = {acc[6:0], data_out};
                vcnt++;
                if (!prev_dv) runs++;
                if (bit_idx == 7) begin
                    if (sb.size() == 0) chk("unexpected_byte", 1, 0);
                    else chk("byte_value", 32'(acc), 32'(sb.pop_front()));
                    bit_idx = 0;
                end else begin
                    bit_idx++;
                end
            end
            prev_dv = data_valid;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] b, input bit accept);
        byte_in_valid = 1'b1;
        byte_in       = b;
        if (accept) sb.push_back(b);
        tick();
        byte_in_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vec_t vecs [4];
        int   v0, r0;
        bit   found;

        vecs[0] = '{n: 3, b0: 8'h3C, b1: 8'hFF, b2: 8'h01, exp_valid: 24};
        vecs[1] = '{n: 2, b0: 8'h00, b1: 8'h80, b2: 8'h00, exp_valid: 16};
        vecs[2] = '{n: 1, b0: 8'h7E, b1: 8'h00, b2: 8'h00, exp_valid: 8};
        vecs[3] = '{n: 2, b0: 8'h55, b1: 8'hAA, b2: 8'h00, exp_valid: 16};

        // Reset state
        #12;
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_in_ready", 32'(byte_in_ready), 1);
        chk("rst_req", 32'(ready_for_transfer_out), 0);
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_bc", 32'(byte_counter), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        ticks(2);

        // Single byte latency with transfer center already ready
        ready_for_transfer_in = 1'b1;
        v0 = vcnt; r0 = runs;
        wr(8'hA5, 1'b1);
        chk("t1_fill_after_write", 32'(fill_level), 1);
        chk("t1_req_early", 32'(ready_for_transfer_out), 0);
        tick();
        chk("t1_req_pulse", 32'(ready_for_transfer_out), 1);
        chk("t1_dv_early", 32'(data_valid), 0);
        tick();
        chk("t1_req_drop", 32'(ready_for_transfer_out), 0);
        chk("t1_first_dv", 32'(data_valid), 1);
        chk("t1_first_bc", 32'(byte_counter), 0);
        chk("t1_first_bit", 32'(data_out), 1);
        chk("t1_fill_after_load", 32'(fill_level), 0);
        ticks(10);
        chk("t1_valid_cycles", 32'(vcnt - v0), 8);
        chk("t1_runs", 32'(runs - r0), 1);
        chk("t1_dv_end", 32'(data_valid), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // Table-driven back-to-back bursts
        for (int k = 0; k < 4; k++) begin
            v0 = vcnt; r0 = runs;
            wr(vecs[k].b0, 1'b1);
            if (vecs[k].n > 1) wr(vecs[k].b1, 1'b1);
            if (vecs[k].n > 2) wr(vecs[k].b2, 1'b1);
            ticks(8 * vecs[k].n + 6);
            chk($sformatf("row%0d_valid_cycles", k), 32'(vcnt - v0), 32'(vecs[k].exp_valid));
            chk($sformatf("row%0d_contiguous", k), 32'(runs - r0), 1);
            chk($sformatf("row%0d_fill", k), 32'(fill_level), 0);
            chk($sformatf("row%0d_sb_empty", k), 32'(sb.size()), 0);
        end

        // Stall in REQUEST, then drop ready mid-byte
        ready_for_transfer_in = 1'b0;
        v0 = vcnt;
        wr(8'h81, 1'b1);
        ticks(20);
        chk("t3_req_held", 32'(ready_for_transfer_out), 1);
        chk("t3_no_dv", 32'(data_valid), 0);
        chk("t3_no_bits", 32'(vcnt - v0), 0);
        ready_for_transfer_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (data_valid && byte_counter == 3'd3) found = 1'b1;
            else tick();
        end
        chk("t3_reach_bc3", 32'(found), 1);
        ready_for_transfer_in = 1'b0;
        ticks(12);
        chk("t3_valid_cycles", 32'(vcnt - v0), 8);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        chk("t3_idle_req", 32'(ready_for_transfer_out), 0);

        // Fill to DEPTH, one dropped write, then drain in order
        for (int i = 0; i <= DEPTH; i++) wr(8'h10 + 8'(i), i < DEPTH);
        chk("t4_fill_full", 32'(fill_level), DEPTH);
        chk("t4_in_ready", 32'(byte_in_ready), 0);
        chk("t4_overflow", 32'(overflow), 1);
        v0 = vcnt; r0 = runs;
        ready_for_transfer_in = 1'b1;
        ticks(8 * DEPTH + 6);
        chk("t4_valid_cycles", 32'(vcnt - v0), 32'(8 * DEPTH));
        chk("t4_contiguous", 32'(runs - r0), 1);
        chk("t4_sb_empty", 32'(sb.size()), 0);
        chk("t4_overflow_sticky", 32'(overflow), 1);
        chk("t4_in_ready_back", 32'(byte_in_ready), 1);

        // Asynchronous reset in the middle of a byte
        ready_for_transfer_in = 1'b0;
        wr(8'hF0, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        ready_for_transfer_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (data_valid && byte_counter == 3'd4) found = 1'b1;
            else tick();
        end
        chk("t5_reach_bc4", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("t5_dv", 32'(data_valid), 0);
        chk("t5_bc", 32'(byte_counter), 0);
        chk("t5_dout", 32'(data_out), 0);
        chk("t5_fill", 32'(fill_level), 0);
        chk("t5_req", 32'(ready_for_transfer_out), 0);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_in_ready", 32'(byte_in_ready), 1);
        sb.delete();
        ticks(2);
        rst = 1'b0;
        v0 = vcnt;
        ticks(20);
        chk("t5_quiet_after_release", 32'(vcnt - v0), 0);
        chk("t5_fill_after_release", 32'(fill_level), 0);

        // Push on the same edge as the load event
        ready_for_transfer_in = 1'b0;
        v0 = vcnt; r0 = runs;
        wr(8'h5A, 1'b1);
        ticks(2);
        chk("t6_waiting", 32'(ready_for_transfer_out), 1);
        ready_for_transfer_in = 1'b1;
        wr(8'hC3, 1'b1);
        chk("t6_fill_unchanged", 32'(fill_level), 1);
        chk("t6_loaded", 32'(data_valid), 1);
        ticks(20);
        chk("t6_valid_cycles", 32'(vcnt - v0), 16);
        chk("t6_contiguous", 32'(runs - r0), 1);
        chk("t6_sb_empty", 32'(sb.size()), 0);
        chk("t6_fill_end", 32'(fill_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
